// File: rtl/mpy_32_multi.sv
// mpy_32_multi: multi-channel double-precision multiply sequencer
// (Mpy_32 32x32 and Mpy_32_16 32x16) built on shared basic-op units.
//
// Ports:
//   clock           rising-edge clock
//   reset           synchronous, active-high
//   start           job request, sampled only in IDLE
//   mode            0 = Mpy_32, 1 = Mpy_32_16
//   var1, var2      packed operands, channel c at [32c+31:32c]
//   out             packed registered results
//   done            one-cycle pulse when the job completes
//   busy            high in every state except IDLE
//   L_mult_*        operands to / result from the shared L_mult
//   mult_*          operands to / result from the shared mult
//   L_mac_*         operands to / result from the shared L_mac
//   Unit operands are driven to zero in states that do not use them.
//
// Option: define MPY_32_MULTI_OVF_EN to add output ovf, a sticky
// per-job flag of any overflow reported by a unit in use.

module mpy_32_multi #(
  parameter int NUM_CH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [32*NUM_CH-1:0] var1,
  input  logic [32*NUM_CH-1:0] var2,
  output logic [32*NUM_CH-1:0] out,
  output logic                 done,
  output logic                 busy,
  output logic [15:0]          L_mult_outa,
  output logic [15:0]          L_mult_outb,
  input  logic [31:0]          L_mult_in,
  input  logic                 L_mult_overflow,
  output logic [15:0]          mult_outa,
  output logic [15:0]          mult_outb,
  input  logic [15:0]          mult_in,
  input  logic                 mult_overflow,
  output logic [15:0]          L_mac_outa,
  output logic [15:0]          L_mac_outb,
  output logic [31:0]          L_mac_outc,
  input  logic [31:0]          L_mac_in,
  input  logic                 L_mac_overflow
`ifdef MPY_32_MULTI_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int CW =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(NUM_CH - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] S_LMULT = 3'd1;
  localparam logic [2:0] S_MAC1  = 3'd2;
  localparam logic [2:0] S_MAC2  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]           state;
  logic [2:0]           state_d;
  logic [CW-1:0]        ch;
  logic [31:0]          acc;
  logic [32*NUM_CH-1:0] v1_q;
  logic [32*NUM_CH-1:0] v2_q;
  logic                 mode_q;

  logic [31:0] op1;
  logic [31:0] op2;
  logic [15:0] hi1;
  logic [15:0] lo1;
  logic [15:0] hi2;
  logic [15:0] lo2;

  logic st_idle;
  logic st_lmult;
  logic st_mac1;
  logic st_mac2;
  logic st_mac;
  logic accept;
  logic last_step;
  logic ch_last;

  // Operand pair of the channel being worked on.
  always_comb begin
    op1 = '0;
    op2 = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch == CW'(c)) begin
        op1 = v1_q[32*c +: 32];
        op2 = v2_q[32*c +: 32];
      end
    end
  end

  assign hi1 = op1[31:16];
  assign lo1 = op1[15:0];
  assign hi2 = op2[31:16];
  // In Mpy_32_16 the low half of var2 is n.
  assign lo2 = op2[15:0];

  assign st_idle  = (state == IDLE);
  assign st_lmult = (state == S_LMULT);
  assign st_mac1  = (state == S_MAC1);
  assign st_mac2  = (state == S_MAC2);
  assign st_mac   = st_mac1 | st_mac2;
  assign accept   = st_idle & start;
  assign ch_last  = (ch == LAST);

  // Mpy_32_16 finishes a channel after the
  // first L_mac; Mpy_32 needs a second one.
  assign last_step =
    st_mac2 | (st_mac1 & mode_q);

  assign done = (state == S_DONE);
  assign busy = ~st_idle;

  // L_mult: hi1 x hi2, or hi1 x n in 32x16.
  always_comb begin
    L_mult_outa = '0;
    L_mult_outb = '0;
    if (st_lmult) begin
      L_mult_outa = hi1;
      L_mult_outb = mode_q ? lo2 : hi2;
    end
  end

  // mult: cross terms of the DPF product.
  always_comb begin
    mult_outa = '0;
    mult_outb = '0;
    unique case (1'b1)
      st_mac1: begin
        mult_outa = mode_q ? lo1 : hi1;
        mult_outb = lo2;
      end
      st_mac2: begin
        mult_outa = lo1;
        mult_outb = hi2;
      end
      default: ;
    endcase
  end

  // L_mac folds the mult result into acc.
  // Kept apart from the mult block so the
  // mult_in return path is not a false loop.
  assign L_mac_outa = st_mac ? mult_in : '0;
  assign L_mac_outb = st_mac ? 16'd1 : '0;
  assign L_mac_outc = st_mac ? acc : '0;

  always_comb begin
    state_d = state;
    unique case (1'b1)
      st_idle: begin
        if (start) state_d = S_LMULT;
      end
      st_lmult:
        state_d = S_MAC1;
      last_step:
        state_d = ch_last ? S_DONE : S_LMULT;
      st_mac1 & ~mode_q:
        state_d = S_MAC2;
      done:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      ch     <= '0;
      acc    <= '0;
      out    <= '0;
      v1_q   <= '0;
      v2_q   <= '0;
      mode_q <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        v1_q   <= var1;
        v2_q   <= var2;
        mode_q <= mode;
        ch     <= '0;
      end
      if (st_lmult) acc <= L_mult_in;
      if (st_mac)   acc <= L_mac_in;
      if (last_step) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch == CW'(c)) begin
            out[32*c +: 32] <= L_mac_in;
          end
        end
        if (!ch_last) ch <= ch + CW'(1);
      end
    end
  end

`ifdef MPY_32_MULTI_OVF_EN
  logic ovf_hit;

  // Only flags from units actually in use
  // this cycle count.
  assign ovf_hit =
    (st_lmult & L_mult_overflow) |
    (st_mac & (mult_overflow | L_mac_overflow));

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (accept) begin
      ovf <= 1'b0;
    end else if (ovf_hit) begin
      ovf <= 1'b1;
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = ^{L_mult_overflow,
                        mult_overflow,
                        L_mac_overflow};
`endif

endmodule

// File: tb/tb_mpy_32_multi.sv
// tb_mpy_32_multi: directed bench for mpy_32_multi, one instance
// with NUM_CH=1 and one with NUM_CH=2, each with basic-op models.

module tb_mpy_32_multi;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  logic mode;
  logic s1;
  logic s2;
  logic [31:0] v1a;
  logic [31:0] v2a;
  logic [63:0] v1b;
  logic [63:0] v2b;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;

  function automatic logic [31:0] m_lmult(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] p;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    p  = sa * sb;
    if (a == 16'h8000 && b == 16'h8000)
      return 32'h7fff_ffff;
    return p <<< 1;
  endfunction

  function automatic logic [15:0] m_mult(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] p;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    p  = (sa * sb) >>> 15;
    if (a == 16'h8000 && b == 16'h8000)
      return 16'h7fff;
    return p[15:0];
  endfunction

  // Returns {overflow, saturated sum}.
  function automatic logic [32:0] m_lmac(
    input logic [31:0] c,
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [31:0] pr;
    logic [32:0] s;
    pr = m_lmult(a, b);
    s  = {c[31], c} + {pr[31], pr};
    if (s[32] != s[31])
      return {1'b1, s[32] ? 32'h8000_0000
                          : 32'h7fff_ffff};
    return {(a == 16'h8000 && b == 16'h8000),
            s[31:0]};
  endfunction

  logic [31:0] d1_out;
  logic        d1_done;
  logic        d1_busy;
  logic [15:0] d1_lma;
  logic [15:0] d1_lmb;
  logic [31:0] d1_lmi;
  logic        d1_lmo;
  logic [15:0] d1_ma;
  logic [15:0] d1_mb;
  logic [15:0] d1_mi;
  logic        d1_mo;
  logic [15:0] d1_aa;
  logic [15:0] d1_ab;
  logic [31:0] d1_ac;
  logic [31:0] d1_ai;
  logic        d1_ao;

  logic [63:0] d2_out;
  logic        d2_done;
  logic        d2_busy;
  logic [15:0] d2_lma;
  logic [15:0] d2_lmb;
  logic [31:0] d2_lmi;
  logic        d2_lmo;
  logic [15:0] d2_ma;
  logic [15:0] d2_mb;
  logic [15:0] d2_mi;
  logic        d2_mo;
  logic [15:0] d2_aa;
  logic [15:0] d2_ab;
  logic [31:0] d2_ac;
  logic [31:0] d2_ai;
  logic        d2_ao;

`ifdef MPY_32_MULTI_OVF_EN
  logic d1_ovf;
  logic d2_ovf;
`endif

  assign d1_lmi = m_lmult(d1_lma, d1_lmb);
  assign d1_lmo = (d1_lma == 16'h8000) &&
                  (d1_lmb == 16'h8000);
  assign d1_mi  = m_mult(d1_ma, d1_mb);
  assign d1_mo  = (d1_ma == 16'h8000) &&
                  (d1_mb == 16'h8000);
  assign {d1_ao, d1_ai} =
    m_lmac(d1_ac, d1_aa, d1_ab);

  assign d2_lmi = m_lmult(d2_lma, d2_lmb);
  assign d2_lmo = (d2_lma == 16'h8000) &&
                  (d2_lmb == 16'h8000);
  assign d2_mi  = m_mult(d2_ma, d2_mb);
  assign d2_mo  = (d2_ma == 16'h8000) &&
                  (d2_mb == 16'h8000);
  assign {d2_ao, d2_ai} =
    m_lmac(d2_ac, d2_aa, d2_ab);

  mpy_32_multi #(.NUM_CH(1)) u_d1 (
    .clock           (clock),
    .reset           (reset),
    .start           (s1),
    .mode            (mode),
    .var1            (v1a),
    .var2            (v2a),
    .out             (d1_out),
    .done            (d1_done),
    .busy            (d1_busy),
    .L_mult_outa     (d1_lma),
    .L_mult_outb     (d1_lmb),
    .L_mult_in       (d1_lmi),
    .L_mult_overflow (d1_lmo),
    .mult_outa       (d1_ma),
    .mult_outb       (d1_mb),
    .mult_in         (d1_mi),
    .mult_overflow   (d1_mo),
    .L_mac_outa      (d1_aa),
    .L_mac_outb      (d1_ab),
    .L_mac_outc      (d1_ac),
    .L_mac_in        (d1_ai),
    .L_mac_overflow  (d1_ao)
`ifdef MPY_32_MULTI_OVF_EN
    ,
    .ovf             (d1_ovf)
`endif
  );

  mpy_32_multi #(.NUM_CH(2)) u_d2 (
    .clock           (clock),
    .reset           (reset),
    .start           (s2),
    .mode            (mode),
    .var1            (v1b),
    .var2            (v2b),
    .out             (d2_out),
    .done            (d2_done),
    .busy            (d2_busy),
    .L_mult_outa     (d2_lma),
    .L_mult_outb     (d2_lmb),
    .L_mult_in       (d2_lmi),
    .L_mult_overflow (d2_lmo),
    .mult_outa       (d2_ma),
    .mult_outb       (d2_mb),
    .mult_in         (d2_mi),
    .mult_overflow   (d2_mo),
    .L_mac_outa      (d2_aa),
    .L_mac_outb      (d2_ab),
    .L_mac_outc      (d2_ac),
    .L_mac_in        (d2_ai),
    .L_mac_overflow  (d2_ao)
`ifdef MPY_32_MULTI_OVF_EN
    ,
    .ovf             (d2_ovf)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic job1(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        m,
    output int          n
  );
    v1a  = a;
    v2a  = b;
    mode = m;
    s1   = 1'b1;
    tick();
    s1 = 1'b0;
    n  = 1;
    while (!d1_done && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic job2(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        m,
    output int          n
  );
    v1b  = a;
    v2b  = b;
    mode = m;
    s2   = 1'b1;
    tick();
    s2 = 1'b0;
    n  = 1;
    while (!d2_done && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    mode  = 1'b0;
    s1    = 1'b0;
    s2    = 1'b0;
    v1a   = '0;
    v2a   = '0;
    v1b   = '0;
    v2b   = '0;
    tick();
    tick();
    chk("rst d1 out",  d1_out,  0);
    chk("rst d1 done", d1_done, 0);
    chk("rst d1 busy", d1_busy, 0);
    chk("rst d2 out",  d2_out,  0);
    chk("rst d2 done", d2_done, 0);
    chk("rst d2 busy", d2_busy, 0);
    reset = 1'b0;
    tick();

    // 0.5 x 0.5
    job1(32'h4000_0000, 32'h4000_0000,
         1'b0, lat);
    chk("m0 half lat", lat, 4);
    chk("m0 half out", d1_out, 32'h2000_0000);
    chk("m0 busy@done", d1_busy, 1);
    tick();
    chk("m0 done pulse", d1_done, 0);
    chk("m0 idle busy",  d1_busy, 0);

    // lo1 x hi2 cross term
    job1(32'h7fff_7fff, 32'h4000_0000,
         1'b0, lat);
    chk("m0 cross2 out", d1_out, 32'h3fff_fffe);
    tick();

    // negative hi1
    job1(32'hc000_0000, 32'h4000_0000,
         1'b0, lat);
    chk("m0 neg out", d1_out, 32'he000_0000);
    tick();

    // hi1 x lo2 cross term
    job1(32'h4000_0000, 32'h0001_7fff,
         1'b0, lat);
    chk("m0 cross1 out", d1_out, 32'h0000_fffe);
    tick();

    // 32x16, two channels
    job2({32'h2000_0000, 32'h4000_0000},
         {32'h0000_4000, 32'h0000_2000},
         1'b1, lat);
    chk("m1 lat", lat, 5);
    chk("m1 out", d2_out,
        {32'h1000_0000, 32'h1000_0000});
    tick();

    // 32x16: hi of var2 ignored, lo1 x n used
    job2({32'h7fff_0000, 32'h4000_4000},
         {32'h0000_8000, 32'habcd_4000},
         1'b1, lat);
    chk("m1 n out", d2_out,
        {32'h8001_0000, 32'h2000_4000});
    tick();

    // Mpy_32, two channels; ch1 keeps old
    // value until its own step completes
    v1b  = {32'h7fff_7fff, 32'h4000_0000};
    v2b  = {32'h4000_0000, 32'h4000_0000};
    mode = 1'b0;
    s2   = 1'b1;
    tick();
    s2 = 1'b0;
    tick();
    tick();
    tick();
    chk("m0 ch0 early", d2_out[31:0],
        32'h2000_0000);
    chk("m0 ch1 held", d2_out[63:32],
        32'h8001_0000);
    lat = 4;
    while (!d2_done && lat < 40) begin
      tick();
      lat++;
    end
    chk("m0 2ch lat", lat, 7);
    chk("m0 2ch out", d2_out,
        {32'h3fff_fffe, 32'h2000_0000});
    tick();

    // reset in the 3rd busy cycle
    v1b  = {32'h4000_0000, 32'h7fff_7fff};
    v2b  = {32'h4000_0000, 32'h4000_0000};
    mode = 1'b0;
    s2   = 1'b1;
    tick();
    s2 = 1'b0;
    tick();
    tick();
    chk("abort busy3", d2_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort done", d2_done, 0);
    chk("abort busy", d2_busy, 0);
    chk("abort out",  d2_out,  0);
    tick();
    chk("abort no done", d2_done, 0);
    job2({32'h4000_0000, 32'h7fff_7fff},
         {32'h4000_0000, 32'h4000_0000},
         1'b0, lat);
    chk("post abort lat", lat, 7);
    chk("post abort out", d2_out,
        {32'h2000_0000, 32'h3fff_fffe});
    tick();

    // start held high, operands changed
    // while a job runs
    v1a  = 32'h4000_0000;
    v2a  = 32'h4000_0000;
    mode = 1'b0;
    s1   = 1'b1;
    tick();
    v1a = 32'h7fff_7fff;
    lat = 1;
    while (!d1_done && lat < 40) begin
      tick();
      lat++;
    end
    chk("b2b lat1", lat, 4);
    chk("b2b out1", d1_out, 32'h2000_0000);
    tick();
    chk("b2b gap busy", d1_busy, 0);
    tick();
    chk("b2b restart", d1_busy, 1);
    v1a = 32'hc000_0000;
    lat = 1;
    while (!d1_done && lat < 40) begin
      tick();
      lat++;
    end
    s1 = 1'b0;
    chk("b2b lat2", lat, 4);
    chk("b2b out2", d1_out, 32'h3fff_fffe);
    tick();
    tick();
    chk("b2b stop", d1_busy, 0);

`ifdef MPY_32_MULTI_OVF_EN
    job1(32'h8000_0000, 32'h8000_0000,
         1'b0, lat);
    chk("ovf sat out", d1_out, 32'h7fff_ffff);
    chk("ovf set", d1_ovf, 1);
    tick();
    chk("ovf held", d1_ovf, 1);
    job1(32'h4000_0000, 32'h4000_0000,
         1'b0, lat);
    chk("ovf clean", d1_ovf, 0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
